rtc_calendar_core: RTL and testbench

//  Time-of-day and calendar counter chain for the century clock: sec/min/hour/day/month/year.

---
 rtl/rtc_calendar_core_pkg.sv | 49 ++++
 rtl/rtc_calendar_core_if.sv | 35 +++
 rtl/rtc_btn_sync_edge.sv | 29 ++
 rtl/rtc_calendar_core.sv | 182 ++++++++++++++++++
 tb/tb_rtc_calendar_core.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_calendar_core_pkg.sv
// Shared widths, field limits and calendar helpers
// for the century-clock counter chain.
package rtc_calendar_core_pkg;

    localparam int SEC_W   = 6;
    localparam int MIN_W   = 6;
    localparam int HOUR_W  = 5;
    localparam int DAY_W   = 5;
    localparam int MORTH_W = 4;
    localparam int YEAR_W  = 16;

    localparam logic [SEC_W-1:0]   SEC_MAX   = 6'd59;
    localparam logic [MIN_W-1:0]   MIN_MAX   = 6'd59;
    localparam logic [HOUR_W-1:0]  HOUR_MAX  = 5'd23;
    localparam logic [MORTH_W-1:0] MORTH_MAX = 4'd12;

    // Button / set-pulse bit positions
    localparam int BTN_SEC   = 0;
    localparam int BTN_MIN   = 1;
    localparam int BTN_HOUR  = 2;
    localparam int BTN_DAY   = 3;
    localparam int BTN_MORTH = 4;
    localparam int BTN_YEAR  = 5;
    localparam int BTN_N     = 6;

    // Leap test from the year residues mod 4/100/400
    function automatic logic is_leap(
        input logic [1:0] r4,
        input logic [6:0] r100,
        input logic [8:0] r400
    );
        return ((r4 == 2'd0) && (r100 != 7'd0)) || (r400 == 9'd0);
    endfunction

    // Month length table
    function automatic logic [DAY_W-1:0] month_days(
        input logic [MORTH_W-1:0] m,
        input logic               leap
    );
        logic [DAY_W-1:0] d;
        unique case (m)
            4'd2:                   d = leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
            default:                d = 5'd31;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/rtc_calendar_core_if.sv
// Tick, set buttons and calendar fields between the
// clock core and its driver / display path.
interface rtc_calendar_core_if;
    import rtc_calendar_core_pkg::*;

    logic               tick_1s;
    logic               set_sec;
    logic               set_min;
    logic               set_hour;
    logic               set_day;
    logic               set_morth;
    logic               set_year;
    logic [SEC_W-1:0]   sec;
    logic [MIN_W-1:0]   min;
    logic [HOUR_W-1:0]  hour;
    logic [DAY_W-1:0]   day;
    logic [MORTH_W-1:0] morth;
    logic [YEAR_W-1:0]  year;
    logic               day_rollover;

    modport master (
        output tick_1s, set_sec, set_min, set_hour,
        output set_day, set_morth, set_year,
        input  sec, min, hour, day, morth, year,
        input  day_rollover
    );

    modport slave (
        input  tick_1s, set_sec, set_min, set_hour,
        input  set_day, set_morth, set_year,
        output sec, min, hour, day, morth, year,
        output day_rollover
    );

endinterface

// File: rtl/rtc_btn_sync_edge.sv
// Two-flop synchronizer for a raw push-button followed
// by a rising-edge detector: one clk pulse per press.
module rtc_btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // Synchronizer chain plus previous-level register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= btn;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign pulse = s2_q & ~s3_q;

endmodule

// File: rtl/rtc_calendar_core.sv
// sec/min/hour/day/month/year counter chain with Gregorian
// leap handling, increment-only setting and day clamp.
module rtc_calendar_core
    import rtc_calendar_core_pkg::*;
#(
    parameter int YEAR_MIN   = 1,
    parameter int YEAR_MAX   = 9999,
    parameter int YEAR_RESET = 2000
) (
    input logic                clk,
    input logic                rst_n,
    rtc_calendar_core_if.slave bus
);

    localparam logic [YEAR_W-1:0] Y_MIN = YEAR_W'(YEAR_MIN);
    localparam logic [YEAR_W-1:0] Y_MAX = YEAR_W'(YEAR_MAX);
    localparam logic [YEAR_W-1:0] Y_RST = YEAR_W'(YEAR_RESET);

    // Residues of the reset year and of the wrap target year
    localparam logic [1:0] R4_RST   = 2'(YEAR_RESET % 4);
    localparam logic [6:0] R100_RST = 7'(YEAR_RESET % 100);
    localparam logic [8:0] R400_RST = 9'(YEAR_RESET % 400);
    localparam logic [1:0] R4_MIN   = 2'(YEAR_MIN % 4);
    localparam logic [6:0] R100_MIN = 7'(YEAR_MIN % 100);
    localparam logic [8:0] R400_MIN = 9'(YEAR_MIN % 400);

    logic [BTN_N-1:0]   btn_raw;
    logic [BTN_N-1:0]   set_p;

    logic [SEC_W-1:0]   sec_q, sec_d;
    logic [MIN_W-1:0]   min_q, min_d;
    logic [HOUR_W-1:0]  hour_q, hour_d;
    logic [DAY_W-1:0]   day_q, day_d;
    logic [MORTH_W-1:0] morth_q, morth_d;
    logic [YEAR_W-1:0]  year_q, year_d;
    logic [1:0]         r4_q, r4_d;
    logic [6:0]         r100_q, r100_d;
    logic [8:0]         r400_q, r400_d;
    logic               roll_q, roll_d;

    logic               tick;
    logic               c_min, c_hour, c_day, c_mon, c_year;
    logic               inc_mon, inc_year;
    logic [DAY_W-1:0]   dim_q, dim_d;

    assign btn_raw = {bus.set_year, bus.set_morth, bus.set_day,
                      bus.set_hour, bus.set_min, bus.set_sec};

    for (genvar i = 0; i < BTN_N; i++) begin : g_btn
        rtc_btn_sync_edge u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .btn   (btn_raw[i]),
            .pulse (set_p[i])
        );
    end

    // Carry chain, set increments, year residues and day clamp
    always_comb begin
        sec_d    = sec_q;
        min_d    = min_q;
        hour_d   = hour_q;
        day_d    = day_q;
        morth_d  = morth_q;
        year_d   = year_q;
        r4_d     = r4_q;
        r100_d   = r100_q;
        r400_d   = r400_q;
        roll_d   = 1'b0;
        c_min    = 1'b0;
        c_hour   = 1'b0;
        c_day    = 1'b0;
        c_mon    = 1'b0;
        c_year   = 1'b0;
        // A set pulse swallows the tick, so carries only ever come from the tick
        tick     = bus.tick_1s & ~(|set_p);
        dim_q    = month_days(morth_q, is_leap(r4_q, r100_q, r400_q));

        if (tick | set_p[BTN_SEC]) begin
            if (sec_q == SEC_MAX) begin
                sec_d = '0;
                c_min = tick;
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end

        if (c_min | set_p[BTN_MIN]) begin
            if (min_q == MIN_MAX) begin
                min_d  = '0;
                c_hour = c_min;
            end else begin
                min_d = min_q + 6'd1;
            end
        end

        if (c_hour | set_p[BTN_HOUR]) begin
            if (hour_q == HOUR_MAX) begin
                hour_d = '0;
                c_day  = c_hour;
            end else begin
                hour_d = hour_q + 5'd1;
            end
        end

        if (c_day | set_p[BTN_DAY]) begin
            if (day_q >= dim_q) begin
                day_d  = 5'd1;
                c_mon  = c_day;
                roll_d = c_day;
            end else begin
                day_d = day_q + 5'd1;
            end
        end

        inc_mon = c_mon | set_p[BTN_MORTH];
        if (inc_mon) begin
            if (morth_q == MORTH_MAX) begin
                morth_d = 4'd1;
                c_year  = c_mon;
            end else begin
                morth_d = morth_q + 4'd1;
            end
        end

        inc_year = c_year | set_p[BTN_YEAR];
        if (inc_year) begin
            if (year_q == Y_MAX) begin
                year_d = Y_MIN;
                r4_d   = R4_MIN;
                r100_d = R100_MIN;
                r400_d = R400_MIN;
            end else begin
                year_d = year_q + 16'd1;
                r4_d   = r4_q + 2'd1;
                r100_d = (r100_q == 7'd99)  ? 7'd0 : r100_q + 7'd1;
                r400_d = (r400_q == 9'd399) ? 9'd0 : r400_q + 9'd1;
            end
        end

        dim_d = month_days(morth_d, is_leap(r4_d, r100_d, r400_d));
        if ((inc_mon | inc_year) && (day_d > dim_d)) begin
            day_d = dim_d;
        end
    end

    // Calendar state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_q   <= '0;
            min_q   <= '0;
            hour_q  <= '0;
            day_q   <= 5'd1;
            morth_q <= 4'd1;
            year_q  <= Y_RST;
            r4_q    <= R4_RST;
            r100_q  <= R100_RST;
            r400_q  <= R400_RST;
            roll_q  <= 1'b0;
        end else begin
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            day_q   <= day_d;
            morth_q <= morth_d;
            year_q  <= year_d;
            r4_q    <= r4_d;
            r100_q  <= r100_d;
            r400_q  <= r400_d;
            roll_q  <= roll_d;
        end
    end

    assign bus.sec          = sec_q;
    assign bus.min          = min_q;
    assign bus.hour         = hour_q;
    assign bus.day          = day_q;
    assign bus.morth        = morth_q;
    assign bus.year         = year_q;
    assign bus.day_rollover = roll_q;

endmodule

// File: tb/tb_rtc_calendar_core.sv
// Bench for rtc_calendar_core: calendar-level model checked
// every cycle plus literal expectations at key dates.
module tb_rtc_calendar_core;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rtc_calendar_core_if bus ();

    rtc_calendar_core #(
        .YEAR_MIN   (1),
        .YEAR_MAX   (9999),
        .YEAR_RESET (2000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model state: plain calendar integers
    int m_sec, m_min, m_hour, m_day, m_mon, m_year;
    bit m_roll;
    logic [5:0] m_set = '0;
    int pm, py, t;

    function automatic bit leap_year(input int y);
        return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    endfunction

    function automatic int mdays(input int m, input int y);
        if (m == 2) return leap_year(y) ? 29 : 28;
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input int exp);
        checks++;
        if (got !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_date(input string tag, input int h, input int mi, input int s,
                            input int d, input int mo, input int y);
        chk({tag, ".hour"}, 32'(bus.hour), h);
        chk({tag, ".min"}, 32'(bus.min), mi);
        chk({tag, ".sec"}, 32'(bus.sec), s);
        chk({tag, ".day"}, 32'(bus.day), d);
        chk({tag, ".morth"}, 32'(bus.morth), mo);
        chk({tag, ".year"}, 32'(bus.year), y);
    endtask

    // Reference model: set pulses apply field-wise; a tick adds one second
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sec = 0; m_min = 0; m_hour = 0;
            m_day = 1; m_mon = 1; m_year = 2000;
            m_roll = 1'b0;
        end else begin
            m_roll = 1'b0;
            if (m_set != 6'd0) begin
                pm = m_mon;
                py = m_year;
                if (m_set[0]) m_sec = (m_sec + 1) % 60;
                if (m_set[1]) m_min = (m_min + 1) % 60;
                if (m_set[2]) m_hour = (m_hour + 1) % 24;
                if (m_set[3]) m_day = (m_day >= mdays(m_mon, m_year)) ? 1 : m_day + 1;
                if (m_set[4]) m_mon = m_mon % 12 + 1;
                if (m_set[5]) m_year = (m_year == 9999) ? 1 : m_year + 1;
                if ((m_mon != pm || m_year != py) && m_day > mdays(m_mon, m_year))
                    m_day = mdays(m_mon, m_year);
            end else if (bus.tick_1s) begin
                t = (m_hour * 60 + m_min) * 60 + m_sec + 1;
                if (t == 86400) begin
                    t = 0;
                    if (m_day < mdays(m_mon, m_year)) begin
                        m_day++;
                    end else begin
                        m_day = 1;
                        m_roll = 1'b1;
                        if (m_mon < 12) m_mon++;
                        else begin
                            m_mon = 1;
                            m_year = (m_year == 9999) ? 1 : m_year + 1;
                        end
                    end
                end
                m_hour = t / 3600;
                m_min = (t / 60) % 60;
                m_sec = t % 60;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc.sec", 32'(bus.sec), m_sec);
            chk("cyc.min", 32'(bus.min), m_min);
            chk("cyc.hour", 32'(bus.hour), m_hour);
            chk("cyc.day", 32'(bus.day), m_day);
            chk("cyc.morth", 32'(bus.morth), m_mon);
            chk("cyc.year", 32'(bus.year), m_year);
            chk("cyc.roll", 32'(bus.day_rollover), int'(m_roll));
        end
    end

    task automatic drive_btn(input logic [5:0] v);
        bus.set_sec   = v[0];
        bus.set_min   = v[1];
        bus.set_hour  = v[2];
        bus.set_day   = v[3];
        bus.set_morth = v[4];
        bus.set_year  = v[5];
    endtask

    // One press of every button in mask; pulse lands on the third edge
    task automatic press(input logic [5:0] mask, input logic with_tick);
        drive_btn(mask);
        @(posedge clk); @(negedge clk);
        drive_btn(6'd0);
        @(posedge clk); @(negedge clk);
        m_set = mask;
        bus.tick_1s = with_tick;
        @(posedge clk); @(negedge clk);
        m_set = 6'd0;
        bus.tick_1s = 1'b0;
    endtask

    task automatic tick_once();
        bus.tick_1s = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.tick_1s = 1'b0;
    endtask

    task automatic set_to(input int h, input int mi, input int s,
                          input int d, input int mo, input int y);
        int ny, nh, nmi, ns, n, nmo, nd, dm;
        ny  = (y - m_year + 9999) % 9999;
        nh  = (h - m_hour + 24) % 24;
        nmi = (mi - m_min + 60) % 60;
        ns  = (s - m_sec + 60) % 60;
        n = ny;
        if (nh > n) n = nh;
        if (nmi > n) n = nmi;
        if (ns > n) n = ns;
        for (int i = 0; i < n; i++)
            press({i < ny, 1'b0, 1'b0, i < nh, i < nmi, i < ns}, 1'b0);
        nmo = (mo - m_mon + 12) % 12;
        for (int i = 0; i < nmo; i++) press(6'b010000, 1'b0);
        dm = mdays(m_mon, m_year);
        nd = (d - m_day + dm) % dm;
        for (int i = 0; i < nd; i++) press(6'b001000, 1'b0);
    endtask

    initial begin
        bus.tick_1s = 1'b0;
        drive_btn(6'd0);
        repeat (3) @(negedge clk);
        chk_date("rst", 0, 0, 0, 1, 1, 2000);
        chk("rst.roll", 32'(bus.day_rollover), 0);
        rst_n = 1'b1;

        // Count, then reset mid-count
        bus.tick_1s = 1'b1;
        repeat (5) @(negedge clk);
        bus.tick_1s = 1'b0;
        chk("count5.sec", 32'(bus.sec), 5);
        bus.tick_1s = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_date("midrst", 0, 0, 0, 1, 1, 2000);
        bus.tick_1s = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 2000 is leap
        set_to(23, 59, 59, 28, 2, 2000);
        tick_once();
        chk_date("leap2000", 0, 0, 0, 29, 2, 2000);

        // Clamp on month set
        set_to(0, 0, 0, 31, 1, 2023);
        press(6'b010000, 1'b0);
        chk_date("clamp_jan", 0, 0, 0, 28, 2, 2023);

        // Full cascade into 2024
        set_to(23, 59, 59, 31, 12, 2023);
        tick_once();
        chk_date("newyear", 0, 0, 0, 1, 1, 2024);
        chk("newyear.roll", 32'(bus.day_rollover), 1);
        @(negedge clk);
        chk("newyear.roll_off", 32'(bus.day_rollover), 0);

        set_to(23, 59, 59, 28, 2, 2024);
        tick_once();
        chk_date("leap2024", 0, 0, 0, 29, 2, 2024);
        press(6'b100000, 1'b0);
        chk_date("clamp_year", 0, 0, 0, 28, 2, 2025);

        // set_min with tick in the same cycle
        set_to(0, 59, 59, 28, 2, 2025);
        press(6'b000010, 1'b1);
        chk_date("set_vs_tick", 0, 0, 59, 28, 2, 2025);

        // 2100 is not leap
        set_to(23, 59, 59, 28, 2, 2100);
        tick_once();
        chk_date("noleap2100", 0, 0, 0, 1, 3, 2100);

        // Year wrap
        set_to(23, 59, 59, 31, 12, 9999);
        tick_once();
        chk_date("yearwrap", 0, 0, 0, 1, 1, 1);
        chk("yearwrap.roll", 32'(bus.day_rollover), 1);

        for (int y = 1; y <= 4; y++) begin
            set_to(23, 59, 59, 28, 2, y);
            tick_once();
            chk_date($sformatf("feb_y%0d", y), 0, 0, 0,
                     (y == 4) ? 29 : 1, (y == 4) ? 2 : 3, y);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
